bcd_serial_addsub: RTL and testbench
====================================

# bcd_serial_addsub

Parametrised, digit-serial packed-BCD adder/subtractor for DIGITS-digit operands. It processes one BCD digit per clock, least-significant digit first, and carries the decimal carry or borrow in a register between digits. Operands arrive and results leave through valid/ready handshakes, so the block sits between operand-source and result-sink stages in the decimal datapath. It is the multi-digit, sequential successor to the team's fixed two-digit combinational BCD adder.

## Interface
- DIGITS, default 4: number of BCD digits per operand (≥1); data width is 4*DIGITS.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand strobe.
- in_ready  output  1  block can accept operands.
- A  input  4*DIGITS  packed BCD operand; digit i is A[4i+3:4i].
- B  input  4*DIGITS  packed BCD operand.
- Cin  input  1  carry-in for add; borrow-in for subtract.
- Sub  input  1  1 selects A−B−Cin (honoured only with BCD_SUB_EN).
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- S  output  4*DIGITS  packed BCD result.
- Cout  output  1  decimal carry-out for add; 1 means "no borrow" for subtract.
- Err  output  1  one or more operand digits was >9.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- in_ready = (state==IDLE).
- **IDLE → CALC** on in_valid&&in_ready:
  - latch A, B, Sub;
  - clear the digit index and the error flag;
  - carry register = Sub ? !Cin : Cin.
- **CALC**, each cycle, for digit i:
  - b' = Sub ? (9 − B_i) : B_i;
  - raw = A_i + b' + carry (5-bit, range 0..19);
  - if raw>9: S_i = (raw+6)[3:0] and carry=1; otherwise S_i = raw[3:0] and carry=0;
  - error flag |= (A_i>9)||(B_i>9).
  - The same correction rule applies to invalid digits; the result is then undefined, but Err is defined.
- **CALC → DONE** after digit DIGITS−1 is processed.
  - Cout = final carry. S, Cout and Err are registered and stable throughout DONE.
- **DONE → IDLE** on out_ready. out_valid = (state==DONE).
- Subtract with Cout=0 returns the ten's complement of |A−B−Cin|.
- in_valid outside IDLE is ignored. Operands need not be held after acceptance.
- Reset mid-operation aborts the operation:
  - state returns to IDLE;
  - no out_valid is produced;
  - the partial result is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, S=0, Cout=0, Err=0.
- Accept edge at cycle t → out_valid rises at edge t+DIGITS.
- Minimum spacing between accepts is DIGITS+2 cycles: the CALC cycles, one DONE cycle, then IDLE.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.
- S/Cout/Err are held until the DONE→IDLE edge, then retain their values (only out_valid drops).

## Configuration
- Macro: BCD_SUB_EN.
- Defined: the Sub port selects subtraction as described above.
- Undefined: Sub is present but ignored (treated as 0), and the nine's-complement logic is not generated.

## Structure
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W = 4;
  - typedef bcd_digit_t (logic [3:0]);
  - the FSM state enum (IDLE, CALC, DONE).
- Sub-module bcd_digit_add is combinational:
  - inputs: a, b, cin (digit), with an optional sub input under BCD_SUB_EN;
  - outputs: s, cout, err;
  - the top level instantiates it once and muxes digit i into it.
- The top level owns the FSM, digit index, operand/result shift registers and the handshakes.

## Test plan
- DIGITS=4, A=0x1234, B=0x5678, Cin=0 → S=0x6912, Cout=0, Err=0; out_valid exactly 4 cycles after accept.
- A=0x9999, B=0x0001, Cin=0 → S=0x0000, Cout=1. A=0x0000, B=0x0000, Cin=1 → S=0x0001, Cout=0.
- BCD_SUB_EN: A=0x0500, B=0x0123, Sub=1 → S=0x0377, Cout=1. A=0x0100, B=0x0200, Sub=1 → S=0x9900, Cout=0.
- A=0x00A1, B=0x0001 → Err=1 with out_valid. A following valid operation → Err=0.
- Backpressure: out_ready held 0 for 5 cycles → S/Cout stable, in_ready=0, extra in_valid ignored. out_ready=1 → IDLE next edge.
- rst_n pulsed low during the CALC cycle for digit 2 → outputs at reset values immediately; the next operation (0x1234+0x5678) yields 0x6912.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder/subtractor.
// Holds the digit width, the digit type and the sequencer state encoding.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for bcd_serial_addsub.
// The master side is the operand source and result sink; the slave side is the adder.
interface bcd_serial_addsub_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  // Operand channel
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;

  // Result channel
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         Err;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, Cout, Err
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, Cout, Err
  );

endinterface : bcd_serial_addsub_if

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add (or nine's-complement subtract) with decimal correction.
// Purely combinational. The sub input exists only when BCD_SUB_EN is defined.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
`ifdef BCD_SUB_EN
  input  logic       sub,
`endif
  output bcd_digit_t s,
  output logic       cout,
  output logic       err
);

  bcd_digit_t b_eff;
  logic [4:0] raw;
  logic [4:0] adj;

  // Binary digit sum, then +6 correction whenever the sum leaves the decimal range.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first or full if/else), otherwise synthesis infers a latch.
`ifdef BCD_SUB_EN
    // Wraps for invalid b digits; the result is then undefined but err still flags it.
    b_eff = sub ? bcd_digit_t'(4'd9 - b) : b;
`else
    b_eff = b;
`endif
    raw = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      s    = adj[3:0];
      cout = 1'b1;
    end else begin
      s    = raw[3:0];
      cout = 1'b0;
    end
    err = (a > 4'd9) || (b > 4'd9);
  end

endmodule : bcd_digit_add

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Operands are accepted in IDLE, digits are processed in CALC, and the result
// is presented in DONE until the sink takes it.
// Optional feature macro: BCD_SUB_EN (enables the Sub input / subtraction).
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_addsub_if.slave  bus
);

  localparam int                W        = BCD_DIGIT_W * DIGITS;
  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic [W-1:0]     s_q,     s_d;
  logic             carry_q, carry_d;
  logic             err_q,   err_d;
  logic             cout_q,  cout_d;

  bcd_digit_t       dig_s;
  logic             dig_cout;
  logic             dig_err;
  logic [W+3:0]     s_shift;

`ifdef BCD_SUB_EN
  logic             sub_q,   sub_d;
`else
  // Sub is part of the bus but has no effect in an add-only build.
  logic             unused_sub;
  assign unused_sub = bus.Sub;
`endif

  // The low digit of each operand shift register is always the digit being processed.
  bcd_digit_add u_digit (
    .a    (a_q[BCD_DIGIT_W-1:0]),
    .b    (b_q[BCD_DIGIT_W-1:0]),
    .cin  (carry_q),
`ifdef BCD_SUB_EN
    .sub  (sub_q),
`endif
    .s    (dig_s),
    .cout (dig_cout),
    .err  (dig_err)
  );

  // New digits enter the result at the top so that after DIGITS shifts digit 0 sits at the bottom.
  assign s_shift = {dig_s, s_q};

  // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    err_d   = err_q;
    cout_d  = cout_q;
`ifdef BCD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          a_d     = bus.A;
          b_d     = bus.B;
          idx_d   = '0;
          err_d   = 1'b0;
`ifdef BCD_SUB_EN
          sub_d   = bus.Sub;
          // Subtraction is A + nines(B) + 1 - Cin, so the borrow-in enters inverted.
          carry_d = bus.Sub ? !bus.Cin : bus.Cin;
`else
          carry_d = bus.Cin;
`endif
        end
      end
      CALC: begin
        a_d     = a_q >> BCD_DIGIT_W;
        b_d     = b_q >> BCD_DIGIT_W;
        s_d     = s_shift[W+3:BCD_DIGIT_W];
        carry_d = dig_cout;
        err_d   = err_q | dig_err;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = dig_cout;
          idx_d   = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: operand/result shift registers, carry, index and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain registers, not a memory array, so they all take a
    // reset value; the result outputs must read zero straight out of reset.
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cout_q  <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      cout_q  <= cout_d;
`ifdef BCD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.Err       = err_q;

endmodule : bcd_serial_addsub

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4).
// Expected results come from a decimal-arithmetic reference model.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] r = '0;
    longint       x = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] s, output logic cout, output logic err);
    longint m = 1;
    longint d;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    err = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) err = 1'b1;
    if (SUB_EN && sub) begin
      d = bcd2int(a) - bcd2int(b) - longint'(cin);
      if (d >= 0) begin s = int2bcd(d);     cout = 1'b1; end
      else        begin s = int2bcd(m + d); cout = 1'b0; end
    end else begin
      d    = bcd2int(a) + bcd2int(b) + longint'(cin);
      cout = (d >= m);
      s    = int2bcd(d % m);
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- drivers (no checking) ----------------
  // Presents one operand set, waits for the accept edge, then counts cycles to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.Cin = 1'($urandom); bus.Sub = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.S !== '0)           begin bad++; $display("FAIL reset_S got=%h want=0", bus.S); end
    total++; if (bus.Cout !== 1'b0)      begin bad++; $display("FAIL reset_Cout got=%b want=0", bus.Cout); end
    total++; if (bus.Err !== 1'b0)       begin bad++; $display("FAIL reset_Err got=%b want=0", bus.Err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed_add();
    logic [W-1:0] va[3] = '{16'h1234, 16'h9999, 16'h0000};
    logic [W-1:0] vb[3] = '{16'h5678, 16'h0001, 16'h0000};
    logic         vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[3] = '{16'h6912, 16'h0000, 16'h0001};
    logic         ec[3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, lat);
      total++; if (lat != DIGITS)      begin bad++; $display("FAIL add%0d_latency got=%0d want=%0d", i, lat, DIGITS); end
      total++; if (bus.S !== es[i])    begin bad++; $display("FAIL add%0d_S got=%h want=%h", i, bus.S, es[i]); end
      total++; if (bus.Cout !== ec[i]) begin bad++; $display("FAIL add%0d_Cout got=%b want=%b", i, bus.Cout, ec[i]); end
      total++; if (bus.Err !== 1'b0)   begin bad++; $display("FAIL add%0d_Err got=%b want=0", i, bus.Err); end
      take_result();
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va[2] = '{16'h0500, 16'h0100};
    logic [W-1:0] vb[2] = '{16'h0123, 16'h0200};
`ifdef BCD_SUB_EN
    logic [W-1:0] es[2] = '{16'h0377, 16'h9900};
    logic         ec[2] = '{1'b1, 1'b0};
`else
    // Add-only build: Sub is ignored and the operands are summed.
    logic [W-1:0] es[2] = '{16'h0623, 16'h0300};
    logic         ec[2] = '{1'b0, 1'b0};
`endif
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], 1'b0, 1'b1, lat);
      total++; if (bus.S !== es[i])    begin bad++; $display("FAIL sub%0d_S got=%h want=%h", i, bus.S, es[i]); end
      total++; if (bus.Cout !== ec[i]) begin bad++; $display("FAIL sub%0d_Cout got=%b want=%b", i, bus.Cout, ec[i]); end
      take_result();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es;
    logic cin, sub, ec, ee;
    int lat;
    for (int n = 0; n < 24; n++) begin
      a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom); sub = 1'($urandom);
      model(a, b, cin, sub, es, ec, ee);
      run_op(a, b, cin, sub, lat);
      total++;
      if (lat != DIGITS || bus.S !== es || bus.Cout !== ec || bus.Err !== ee) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got lat=%0d S=%h C=%b E=%b want lat=%0d S=%h C=%b E=%b",
                 n, a, b, cin, sub, lat, bus.S, bus.Cout, bus.Err, DIGITS, es, ec, ee);
      end
      take_result();
    end
  endtask

  task automatic test_err();
    int lat;
    run_op(16'h00A1, 16'h0001, 1'b0, 1'b0, lat);
    total++; if (lat != DIGITS)    begin bad++; $display("FAIL err_lsd_latency got=%0d want=%0d", lat, DIGITS); end
    total++; if (bus.Err !== 1'b1) begin bad++; $display("FAIL err_lsd_Err got=%b want=1", bus.Err); end
    take_result();
    run_op(16'h0000, 16'hF000, 1'b0, 1'b0, lat);
    total++; if (bus.Err !== 1'b1) begin bad++; $display("FAIL err_msd_Err got=%b want=1", bus.Err); end
    take_result();
    run_op(16'h0012, 16'h0034, 1'b0, 1'b0, lat);
    total++; if (bus.Err !== 1'b0)     begin bad++; $display("FAIL err_clear_Err got=%b want=0", bus.Err); end
    total++; if (bus.S !== 16'h0046)   begin bad++; $display("FAIL err_clear_S got=%h want=0046", bus.S); end
    take_result();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, es;
    logic ec, ee;
    int lat;
    a = rand_bcd(); b = rand_bcd();
    model(a, b, 1'b1, 1'b0, es, ec, ee);
    run_op(a, b, 1'b1, 1'b0, lat);
    bus.A = rand_bcd(); bus.B = rand_bcd(); bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.S !== es || bus.Cout !== ec) begin
        bad++;
        $display("FAIL hold%0d got ov=%b ir=%b S=%h C=%b want ov=1 ir=0 S=%h C=%b",
                 i, bus.out_valid, bus.in_ready, bus.S, bus.Cout, es, ec);
      end
    end
    bus.in_valid = 1'b0;
    take_result();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL release_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.S !== es || bus.Cout !== ec) begin
      bad++; $display("FAIL release_retain got S=%h C=%b want S=%h C=%b", bus.S, bus.Cout, es, ec);
    end
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ignored_in_valid got in_ready=%b want=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    bus.A = 16'h1234; bus.B = 16'h5678; bus.Cin = 1'b0; bus.Sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== '0 || bus.Cout !== 1'b0 || bus.Err !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs got ir=%b ov=%b S=%h C=%b E=%b want ir=1 ov=0 S=0 C=0 E=0",
               bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.Err);
    end
    #2 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_out_valid got=%0d cycles want=0", seen); end
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
    total++; if (bus.S !== 16'h6912 || bus.Cout !== 1'b0) begin
      bad++; $display("FAIL after_reset_op got S=%h C=%b want S=6912 C=0", bus.S, bus.Cout);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int           acc[$];
    logic [W-1:0] qs[$];
    logic         qc[$];
    logic [W-1:0] a, b, es, got_s;
    logic         cin, sub, ec, ee, rdy, got_c;
    int           guard = 0;
    bus.out_ready = 1'b1;
    a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom); sub = 1'($urandom);
    model(a, b, cin, sub, es, ec, ee);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.in_valid = 1'b1;
    while ((acc.size() < 3 || qs.size() != 0) && guard < 200) begin
      rdy = bus.in_ready;
      if (bus.out_valid) begin
        total++;
        if (qs.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_out_valid got=1 want=0");
        end else begin
          got_s = qs.pop_front();
          got_c = qc.pop_front();
          if (bus.S !== got_s || bus.Cout !== got_c) begin
            bad++; $display("FAIL b2b_result got S=%h C=%b want S=%h C=%b", bus.S, bus.Cout, got_s, got_c);
          end
        end
      end
      @(posedge clk); #1;
      guard++;
      if (rdy && bus.in_valid) begin
        acc.push_back(cyc); qs.push_back(es); qc.push_back(ec);
        if (acc.size() < 3) begin
          a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom); sub = 1'($urandom);
          model(a, b, cin, sub, es, ec, ee);
          bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (guard >= 200) begin bad++; $display("FAIL b2b_timeout got=%0d cycles want<200", guard); end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] != DIGITS + 2) begin
        bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, acc[i] - acc[i-1], DIGITS + 2);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.Sub       = 1'b0;
    test_reset();
    test_directed_add();
    test_sub();
    test_random();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_serial_addsub
